// File: rtl/bp_sound_cmd_latch.sv
// Sound command mailbox between the Blue Print main CPU board and the sound PCB.
// The main CPU writes a command byte. The block latches it, holds the sound Z80
// NMI low for a fixed number of sound clock ticks, and tracks whether the byte
// has been read. A vblank rising edge raises a timed IRQ that the sound CPU can
// acknowledge early. All outputs come straight from flops.
module bp_sound_cmd_latch #(
    parameter int unsigned NMI_TICKS = 32,
    parameter int unsigned IRQ_TICKS = 64
) (
    input  logic       clk_49m,
    input  logic       reset,
    input  logic       snd_cen,
    input  logic       pause,
    input  logic [7:0] sound_cmd,
    input  logic       sound_cmd_wr,
    input  logic       vblank,
    input  logic       snd_rd_latch,
    input  logic       snd_irq_ack,
    output logic [7:0] snd_data_out,
    output logic       cmd_pending,
    output logic       snd_nmi_n,
    output logic       snd_irq_n,
    output logic [7:0] overrun_cnt
);

    localparam logic [7:0] NMI_LOAD = 8'(NMI_TICKS);
    localparam logic [7:0] IRQ_LOAD = 8'(IRQ_TICKS);

    logic [7:0] data_q, data_d;
    logic       pend_q, pend_d;
    logic       nmi_n_q, nmi_n_d;
    logic       irq_n_q, irq_n_d;
    logic [7:0] ovr_q, ovr_d;
    logic [7:0] nmi_cnt_q, nmi_cnt_d;
    logic [7:0] irq_cnt_q, irq_cnt_d;
    logic       wr_d_q, wr_d_d;
    logic       vb_d_q, vb_d_d;

    logic       wr_evt;
    logic       vb_evt;
    logic       tick;

    assign wr_evt = sound_cmd_wr & ~wr_d_q;
    assign vb_evt = vblank & ~vb_d_q;
    // Timers only advance on an unpaused sound clock enable.
    assign tick   = snd_cen & ~pause;

    // Next-state logic for the latch, the NMI timer and the IRQ timer.
    always_comb begin
        data_d    = data_q;
        pend_d    = pend_q;
        nmi_n_d   = nmi_n_q;
        irq_n_d   = irq_n_q;
        ovr_d     = ovr_q;
        nmi_cnt_d = nmi_cnt_q;
        irq_cnt_d = irq_cnt_q;
        wr_d_d    = sound_cmd_wr;
        vb_d_d    = vblank;

        // A write takes priority over a read and reloads a running NMI
        // without releasing it, so the sound CPU sees no extra falling edge.
        if (wr_evt) begin
            data_d    = sound_cmd;
            pend_d    = 1'b1;
            nmi_cnt_d = NMI_LOAD;
            nmi_n_d   = 1'b0;
            if (pend_q && (ovr_q != 8'hFF)) begin
                ovr_d = ovr_q + 8'd1;
            end else begin
                ovr_d = ovr_q;
            end
        end else begin
            if (snd_rd_latch) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end
            if (!nmi_n_q && tick) begin
                if (nmi_cnt_q <= 8'd1) begin
                    nmi_cnt_d = 8'd0;
                    nmi_n_d   = 1'b1;
                end else begin
                    nmi_cnt_d = nmi_cnt_q - 8'd1;
                    nmi_n_d   = 1'b0;
                end
            end else begin
                nmi_cnt_d = nmi_cnt_q;
                nmi_n_d   = nmi_n_q;
            end
        end

        // A new vblank edge beats a same-cycle acknowledge. An acknowledge
        // while the IRQ is already released has no effect.
        if (vb_evt) begin
            irq_n_d   = 1'b0;
            irq_cnt_d = IRQ_LOAD;
        end else if (!irq_n_q) begin
            if (snd_irq_ack) begin
                irq_n_d   = 1'b1;
                irq_cnt_d = 8'd0;
            end else if (tick) begin
                if (irq_cnt_q <= 8'd1) begin
                    irq_n_d   = 1'b1;
                    irq_cnt_d = 8'd0;
                end else begin
                    irq_n_d   = 1'b0;
                    irq_cnt_d = irq_cnt_q - 8'd1;
                end
            end else begin
                irq_n_d   = irq_n_q;
                irq_cnt_d = irq_cnt_q;
            end
        end else begin
            irq_n_d   = irq_n_q;
            irq_cnt_d = irq_cnt_q;
        end
    end

    // State registers. vblank history resets high so that a vblank already
    // high at reset release does not raise an IRQ.
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            data_q    <= 8'h00;
            pend_q    <= 1'b0;
            nmi_n_q   <= 1'b1;
            irq_n_q   <= 1'b1;
            ovr_q     <= 8'h00;
            nmi_cnt_q <= 8'h00;
            irq_cnt_q <= 8'h00;
            wr_d_q    <= 1'b0;
            vb_d_q    <= 1'b1;
        end else begin
            data_q    <= data_d;
            pend_q    <= pend_d;
            nmi_n_q   <= nmi_n_d;
            irq_n_q   <= irq_n_d;
            ovr_q     <= ovr_d;
            nmi_cnt_q <= nmi_cnt_d;
            irq_cnt_q <= irq_cnt_d;
            wr_d_q    <= wr_d_d;
            vb_d_q    <= vb_d_d;
        end
    end

    assign snd_data_out = data_q;
    assign cmd_pending  = pend_q;
    assign snd_nmi_n    = nmi_n_q;
    assign snd_irq_n    = irq_n_q;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_bp_sound_cmd_latch.sv
// Bench for bp_sound_cmd_latch. The reference model keeps the number of timer
// ticks still owed to each of NMI and IRQ; an interrupt line is low exactly
// while its count is non-zero. The bench compares the DUT against the model
// every cycle, and literal checks from the directed scenarios pin the model.
module tb_bp_sound_cmd_latch;

    localparam int NMI_T = 32;
    localparam int IRQ_T = 64;

    logic       clk_49m = 1'b0;
    logic       reset;
    logic       snd_cen;
    logic       pause;
    logic [7:0] sound_cmd;
    logic       sound_cmd_wr;
    logic       vblank;
    logic       snd_rd_latch;
    logic       snd_irq_ack;
    logic [7:0] snd_data_out;
    logic       cmd_pending;
    logic       snd_nmi_n;
    logic       snd_irq_n;
    logic [7:0] overrun_cnt;

    bp_sound_cmd_latch #(.NMI_TICKS(NMI_T), .IRQ_TICKS(IRQ_T)) dut (
        .clk_49m(clk_49m), .reset(reset), .snd_cen(snd_cen), .pause(pause),
        .sound_cmd(sound_cmd), .sound_cmd_wr(sound_cmd_wr), .vblank(vblank),
        .snd_rd_latch(snd_rd_latch), .snd_irq_ack(snd_irq_ack),
        .snd_data_out(snd_data_out), .cmd_pending(cmd_pending),
        .snd_nmi_n(snd_nmi_n), .snd_irq_n(snd_irq_n), .overrun_cnt(overrun_cnt)
    );

    always #5 clk_49m = ~clk_49m;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rnd_cen  = 1'b0;

    // Behavioural model state.
    bit model_valid = 1'b0;
    int m_data, m_pend, m_ovr, m_nmi_left, m_irq_left, m_wr_prev, m_vb_prev;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        bit wr_e, vb_e, t;
        if (reset) begin
            m_data = 0; m_pend = 0; m_ovr = 0; m_nmi_left = 0; m_irq_left = 0;
            m_wr_prev = 0; m_vb_prev = 1;
            model_valid = 1'b1;
        end else begin
            wr_e = sound_cmd_wr && (m_wr_prev == 0);
            vb_e = vblank && (m_vb_prev == 0);
            t    = snd_cen && !pause;
            if (wr_e) begin
                if (m_pend == 1 && m_ovr < 255) m_ovr++;
                m_data = sound_cmd;
                m_pend = 1;
                m_nmi_left = NMI_T;
            end else begin
                if (snd_rd_latch) m_pend = 0;
                if (m_nmi_left > 0 && t) m_nmi_left--;
            end
            if (vb_e) m_irq_left = IRQ_T;
            else if (m_irq_left > 0) begin
                if (snd_irq_ack) m_irq_left = 0;
                else if (t) m_irq_left--;
            end
            m_wr_prev = sound_cmd_wr;
            m_vb_prev = vblank;
        end
    endtask

    task automatic compare_all();
        if (model_valid) begin
            cmp("m_data",    32'(snd_data_out), 32'(m_data));
            cmp("m_pending", 32'(cmd_pending),  32'(m_pend));
            cmp("m_nmi_n",   32'(snd_nmi_n),    32'(m_nmi_left == 0));
            cmp("m_irq_n",   32'(snd_irq_n),    32'(m_irq_left == 0));
            cmp("m_overrun", 32'(overrun_cnt),  32'(m_ovr));
        end
    endtask

    // One clock: model update at the edge, compare 1 ns later, pick next cen.
    task automatic clk1();
        @(posedge clk_49m);
        model_step();
        #1;
        compare_all();
        cyc++;
        if (rnd_cen) snd_cen = ($urandom_range(0, 2) == 0);
        else         snd_cen = ((cyc % 4) == 0);
    endtask

    // Idle cycle with the write line low, then one write edge.
    task automatic write(input logic [7:0] b);
        sound_cmd_wr = 1'b0;
        clk1();
        sound_cmd    = b;
        sound_cmd_wr = 1'b1;
        clk1();
        sound_cmd_wr = 1'b0;
    endtask

    task automatic read();
        snd_rd_latch = 1'b1;
        clk1();
        snd_rd_latch = 1'b0;
    endtask

    // Run until k unpaused cen ticks have been applied.
    task automatic run_ticks(input int k);
        int n = 0;
        int g = 0;
        while (n < k && g < 5000) begin
            if (snd_cen && !pause) n++;
            clk1();
            g++;
        end
    endtask

    // Count cen ticks applied while NMI is low, until it releases.
    task automatic nmi_ticks_to_release(output int n);
        int g = 0;
        n = 0;
        while (snd_nmi_n == 1'b0 && g < 5000) begin
            if (snd_cen && !pause) n++;
            clk1();
            g++;
        end
    endtask

    task automatic irq_ticks_to_release(output int n);
        int g = 0;
        n = 0;
        while (snd_irq_n == 1'b0 && g < 5000) begin
            if (snd_cen && !pause) n++;
            clk1();
            g++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1();
        clk1();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; snd_cen = 1'b0; pause = 1'b0; sound_cmd = 8'h00;
        sound_cmd_wr = 1'b0; vblank = 1'b0; snd_rd_latch = 1'b0; snd_irq_ack = 1'b0;
        clk1(); clk1(); clk1();
        cmp("rst_data", 32'(snd_data_out), 32'h00);
        cmp("rst_pend", 32'(cmd_pending), 32'd0);
        cmp("rst_nmi", 32'(snd_nmi_n), 32'd1);
        cmp("rst_irq", 32'(snd_irq_n), 32'd1);
        cmp("rst_ovr", 32'(overrun_cnt), 32'd0);
        reset = 1'b0;

        // 1: write latency and NMI width
        write(8'h5A);
        cmp("t1_data", 32'(snd_data_out), 32'h5A);
        cmp("t1_pend", 32'(cmd_pending), 32'd1);
        cmp("t1_nmi_low", 32'(snd_nmi_n), 32'd0);
        nmi_ticks_to_release(n);
        cmp("t1_nmi_ticks", 32'(n), 32'd32);

        // 2: pending and overrun
        read();
        write(8'h11);
        cmp("t2_pend_a", 32'(cmd_pending), 32'd1);
        read();
        cmp("t2_pend_b", 32'(cmd_pending), 32'd0);
        write(8'h22);
        cmp("t2_pend_c", 32'(cmd_pending), 32'd1);
        write(8'h33);
        cmp("t2_pend_d", 32'(cmd_pending), 32'd1);
        cmp("t2_ovr", 32'(overrun_cnt), 32'd1);
        cmp("t2_data", 32'(snd_data_out), 32'h33);
        for (int i = 0; i < 300; i++) write(8'(i));
        cmp("t2_ovr_sat", 32'(overrun_cnt), 32'hFF);

        // 3: simultaneous write and read, held write level
        do_reset();
        sound_cmd = 8'h77; sound_cmd_wr = 1'b1; snd_rd_latch = 1'b1;
        clk1();
        snd_rd_latch = 1'b0;
        cmp("t3_pend", 32'(cmd_pending), 32'd1);
        cmp("t3_data", 32'(snd_data_out), 32'h77);
        cmp("t3_ovr", 32'(overrun_cnt), 32'd0);
        read();
        for (int i = 0; i < 8; i++) clk1();
        sound_cmd_wr = 1'b0;
        clk1();
        cmp("t3_single_evt", 32'(cmd_pending), 32'd0);
        cmp("t3_ovr_b", 32'(overrun_cnt), 32'd0);

        // 4: vblank IRQ, acked and timed out
        vblank = 1'b1;
        clk1();
        cmp("t4_irq_low", 32'(snd_irq_n), 32'd0);
        run_ticks(5);
        snd_irq_ack = 1'b1;
        clk1();
        snd_irq_ack = 1'b0;
        cmp("t4_ack", 32'(snd_irq_n), 32'd1);
        vblank = 1'b0;
        clk1();
        vblank = 1'b1;
        clk1();
        vblank = 1'b0;
        irq_ticks_to_release(n);
        cmp("t4_irq_ticks", 32'(n), 32'd64);
        snd_irq_ack = 1'b1;
        clk1();
        snd_irq_ack = 1'b0;
        cmp("t4_ack_idle", 32'(snd_irq_n), 32'd1);

        // 5: pause freezes the NMI timer
        write(8'h44);
        run_ticks(10);
        pause = 1'b1;
        for (int i = 0; i < 200; i++) clk1();
        cmp("t5_nmi_paused", 32'(snd_nmi_n), 32'd0);
        pause = 1'b0;
        nmi_ticks_to_release(n);
        cmp("t5_remaining", 32'(n), 32'd22);
        write(8'h66);
        pause = 1'b1;
        for (int i = 0; i < 400; i++) clk1();
        write(8'h99);
        cmp("t5_data_paused", 32'(snd_data_out), 32'h99);
        cmp("t5_nmi_low", 32'(snd_nmi_n), 32'd0);
        pause = 1'b0;
        nmi_ticks_to_release(n);
        cmp("t5_reload", 32'(n), 32'd32);

        // 6: reset mid-operation with vblank held high
        write(8'h12);
        vblank = 1'b1;
        clk1();
        cmp("t6_irq_low", 32'(snd_irq_n), 32'd0);
        cmp("t6_nmi_low", 32'(snd_nmi_n), 32'd0);
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        cmp("t6_rst_nmi", 32'(snd_nmi_n), 32'd1);
        cmp("t6_rst_irq", 32'(snd_irq_n), 32'd1);
        cmp("t6_rst_data", 32'(snd_data_out), 32'h00);
        cmp("t6_rst_pend", 32'(cmd_pending), 32'd0);
        for (int i = 0; i < 50; i++) clk1();
        cmp("t6_no_irq", 32'(snd_irq_n), 32'd1);
        vblank = 1'b0;

        // Randomized traffic, checked against the model every cycle.
        rnd_cen = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            sound_cmd    = 8'($urandom);
            if ($urandom_range(0, 40) == 0) sound_cmd_wr = ~sound_cmd_wr;
            snd_rd_latch = ($urandom_range(0, 7) == 0);
            snd_irq_ack  = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 60) == 0) vblank = ~vblank;
            if ($urandom_range(0, 50) == 0) pause = ~pause;
            reset        = ($urandom_range(0, 999) == 0);
            clk1();
        end
        reset = 1'b0; snd_rd_latch = 1'b0; snd_irq_ack = 1'b0;
        clk1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
